// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Load/store unit that turns byte, halfword and word accesses on a 32-bit
//   byte address into accesses on a word-indexed memory. Byte order is
//   big-endian. Sub-word stores are performed as read-modify-write.
//   FSM: IDLE -> RD -> DONE          (load)
//        IDLE -> WR -> DONE          (word store)
//        IDLE -> RD -> WR -> DONE    (sub-word store)
//
// Optional feature (compile-time macro MISALIGN_TRAP_EN):
//   When defined, a misaligned halfword/word access goes IDLE -> DONE with
//   no memory access, pulsing done and misaligned together. When undefined,
//   the misaligned port does not exist and the ignored low address bits are
//   treated as zero.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req        in   1   start an access (sampled only in IDLE)
//   op_write   in   1   1 = store, 0 = load
//   size       in   2   00 byte, 01 halfword, 10/11 word
//   sign_ext   in   1   sign-extend sub-word loads when 1
//   addr       in   32  byte address
//   wdata      in   32  store data, right-justified for sub-word stores
//   rdata      out  32  load result, held until the next load completes
//   done       out  1   one-cycle completion pulse
//   busy       out  1   high in every non-IDLE state
//   mem_addr   out  32  word index into memory
//   mem_wdata  out  32  memory write data
//   mem_we     out  1   memory write enable
//   mem_re     out  1   memory read enable
//   mem_rdata  in   32  memory read data (combinational while mem_re=1)
//   misaligned out  1   misalignment trap pulse (MISALIGN_TRAP_EN only)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WORD_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        op_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int PAD_W = 32 - WORD_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic        op_write_q;
    logic [1:0]  size_q;
    logic        sign_ext_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        busy_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        mem_re_q;
    logic [31:0] rdata_d;
    logic [31:0] merge_d;
    logic        unused_s;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned_q;
    logic        mis_s;
`endif

    // Upper address bits beyond the memory index are intentionally dropped.
    assign unused_s = ^addr[31:WORD_ADDR_W+2];

    // Extract the addressed lane from a big-endian word and extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'd0;
        h = 16'd0;
        r = 32'd0;
        case (sz)
            2'b00: begin
                case (off)
                    2'b00:   b = w[31:24];
                    2'b01:   b = w[23:16];
                    2'b10:   b = w[15:8];
                    2'b11:   b = w[7:0];
                    default: b = 8'd0;
                endcase
                r = {{24{sx & b[7]}}, b};
            end
            2'b01: begin
                // off[0] is ignored: halfword lanes are selected by off[1].
                if (off[1]) begin
                    h = w[15:0];
                end else begin
                    h = w[31:16];
                end
                r = {{16{sx & h[15]}}, h};
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of a big-endian word with store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] w,
        input logic [15:0] wd,
        input logic [1:0]  sz,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: begin
                case (off)
                    2'b00:   r[31:24] = wd[7:0];
                    2'b01:   r[23:16] = wd[7:0];
                    2'b10:   r[15:8]  = wd[7:0];
                    2'b11:   r[7:0]   = wd[7:0];
                    default: r = w;
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    r[15:0] = wd;
                end else begin
                    r[31:16] = wd;
                end
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Load result and read-modify-write data computed from the memory word.
    always_comb begin
        rdata_d = load_extract(mem_rdata, size_q, off_q, sign_ext_q);
        merge_d = store_merge(mem_rdata, wdata_q[15:0], size_q, off_q);
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment detection on the live request inputs.
    always_comb begin
        if (size == 2'b01) begin
            mis_s = addr[0];
        end else if (size[1]) begin
            mis_s = (addr[1:0] != 2'b00);
        end else begin
            mis_s = 1'b0;
        end
    end
`endif

    // Access FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_write_q   <= 1'b0;
            size_q       <= 2'b00;
            sign_ext_q   <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    if (req) begin
                        op_write_q <= op_write;
                        size_q     <= size;
                        sign_ext_q <= sign_ext;
                        off_q      <= addr[1:0];
                        wdata_q    <= wdata;
                        mem_addr_q <= {{PAD_W{1'b0}}, addr[WORD_ADDR_W+1:2]};
                        busy_q     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                        if (mis_s) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else
`endif
                        if (op_write && size[1]) begin
                            state_q     <= S_WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q  <= S_RD;
                            mem_re_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    mem_re_q <= 1'b0;
                    if (op_write_q) begin
                        state_q     <= S_WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_d;
                    end else begin
                        state_q <= S_DONE;
                        rdata_q <= rdata_d;
                        done_q  <= 1'b1;
                    end
                end
                S_WR: begin
                    mem_we_q <= 1'b0;
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                end
                S_DONE: begin
                    state_q      <= S_IDLE;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    misaligned_q <= 1'b0;
`endif
                end
                default: begin
                    state_q      <= S_IDLE;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_re_q     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                    misaligned_q <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
`ifdef MISALIGN_TRAP_EN
    assign misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed test of mem_access_unit against a small word memory. The driver
// pushes the hand-computed expected rdata/latency of each access into a
// scoreboard queue; a monitor pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        op_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    logic [31:0] mem [0:1023];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        int          lat;
        int          issue;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   we_count = 0;
    int   overlap_cnt = 0;
    logic [31:0] last_we_addr = 32'd0;

    mem_access_unit #(.WORD_ADDR_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_write  (op_write),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned(misaligned)
`endif
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure latency from req to done.
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end
    assign mem_rdata = mem_re ? mem[mem_addr[9:0]] : 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Monitor: bus protocol counters and scoreboard comparison on done.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            we_count++;
            last_we_addr = mem_addr;
        end
        if (mem_we && mem_re) overlap_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_rdata"}, rdata, e.rdata);
                check({e.name, "_latency"}, cyc - e.issue, e.lat);
                check({e.name, "_busy"}, {31'd0, busy}, 32'd1);
`ifdef MISALIGN_TRAP_EN
                check({e.name, "_misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
`endif
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic access(input string nm, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int lat, input logic mis,
                          input int hold);
        exp_t e;
        @(negedge clk);
        op_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        e.name = nm; e.rdata = exp_rd; e.lat = lat; e.issue = cyc; e.mis = mis;
        sb.push_back(e);
        repeat (hold) @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check({nm, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int we0;
        rst_n = 1'b0; req = 1'b0; op_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0; pl_en = 1'b0; pl_addr = 10'd0; pl_data = 32'd0;
        #7;
        check("rst_rdata", rdata, 32'd0);
        check("rst_ctrl", {28'd0, done, busy, mem_we, mem_re}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        preload(10'd8,  32'h80FF7F01);
        preload(10'd12, 32'h11223344);
        preload(10'd16, 32'h8001C0DE);
        preload(10'd1,  32'hCAFEF00D);
        preload(10'd20, 32'h11223344);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load.
        we0 = we_count;
        access("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1'b0, 1);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        check("sw_we_cycles", we_count - we0, 32'd1);
        check("sw_we_addr", last_we_addr, 32'd4);
        access("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1);

        // Byte loads, big-endian lanes.
        access("lb_21",  1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'hFFFFFFFF, 2, 1'b0, 1);
        access("lbu_21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h000000FF, 2, 1'b0, 1);
        access("lb_23",  1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h00000001, 2, 1'b0, 1);
        access("lb_20",  1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFFFF80, 2, 1'b0, 1);
        // req held into RD: the second sample must be ignored.
        access("lbu_22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h0000007F, 2, 1'b0, 2);

        // Byte store read-modify-write; rdata must hold the last load.
        we0 = we_count;
        access("sb_32", 1'b1, 2'b00, 1'b0, 32'h32, 32'hFFFFFFAA, 32'h0000007F, 3, 1'b0, 1);
        check("sb_mem", mem[12], 32'h1122AA44);
        check("sb_we_cycles", we_count - we0, 32'd1);

        // Halfword loads and store.
        access("lh_42",  1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'hFFFFC0DE, 2, 1'b0, 1);
        access("lhu_40", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 32'h00008001, 2, 1'b0, 1);
        access("sh_40",  1'b1, 2'b01, 1'b0, 32'h40, 32'hFFFF1234, 32'h00008001, 3, 1'b0, 1);
        check("sh_mem", mem[16], 32'h1234C0DE);

        // Misaligned accesses.
        we0 = we_count;
`ifdef MISALIGN_TRAP_EN
        access("lw_06",  1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h00008001, 1, 1'b1, 1);
        access("lhu_43", 1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 32'h00008001, 1, 1'b1, 1);
`else
        access("lw_06",  1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'hCAFEF00D, 2, 1'b0, 1);
        access("lhu_43", 1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 32'h0000C0DE, 2, 1'b0, 1);
`endif
        check("mis_no_write", we_count - we0, 32'd0);

        // Word index wraps modulo 1024 words.
        access("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1);

        // Reset asserted during RD of a sub-word store.
        we0 = we_count;
        @(negedge clk);
        op_write = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h51; wdata = 32'h55; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("rmw_in_rd", {31'd0, mem_re}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_ctrl", {28'd0, done, busy, mem_we, mem_re}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_write", we_count - we0, 32'd0);
        check("midrst_mem", mem[20], 32'h11223344);
        access("lw_50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h11223344, 2, 1'b0, 1);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        check("re_we_overlap", overlap_cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
